// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm ringer sequencer.
package alarm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      RINGING,
      SNOOZE,
      DONE
   } alarm_state_t;

   localparam int DEF_RING_SECS   = 60;
   localparam int DEF_SNOOZE_SECS = 300;
   localparam int DEF_MAX_SNOOZE  = 3;

endpackage

// File: rtl/sec_counter.sv
// Tick-enabled second counter with synchronous clear; expire pulses on the
// tick that completes LIMIT counted ticks.
module sec_counter #(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             tick,
   input  logic [CNT_W-1:0] limit,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   assign expire = en & tick & (cnt == (limit - CNT_W'(1)));

   // clr wins over a same-cycle tick, so a tick in a state's entry cycle is not counted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && tick) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringer sequencer: arm, edge-triggered ring, snooze/stop, auto-off.
// Define ALARM_BEEP_EN for a 0.5 Hz on/off ringer instead of a steady tone.
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = DEF_RING_SECS,
   parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
   parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE,
   parameter int CNT_W       = 9,
   localparam int SU_W       = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tick_1s,
   input  logic            match,
   input  logic            alarm_en,
   input  logic            snooze,
   input  logic            stop,
   output logic            ringer,
   output logic            ringing,
   output logic            snoozing,
   output logic [SU_W-1:0] snooze_used
);

   localparam logic [CNT_W-1:0] RING_LIM   = CNT_W'(RING_SECS);
   localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(SNOOZE_SECS);

   alarm_state_t     state, state_nx;
   logic             match_q;
   logic             trig;
   logic             can_snooze;
   logic             expire;
   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_limit;
   logic             ringer_nx;
   logic [SU_W-1:0]  used_nx;

   assign trig       = match & ~match_q;
   assign can_snooze = (int'(snooze_used) < MAX_SNOOZE);
   assign cnt_en     = (state == RINGING) || (state == SNOOZE);
   assign cnt_clr    = (state_nx != state);
   assign cnt_limit  = (state == SNOOZE) ? SNOOZE_LIM : RING_LIM;

   sec_counter #(
      .CNT_W (CNT_W)
   ) u_sec_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .tick   (tick_1s),
      .limit  (cnt_limit),
      .expire (expire)
   );

   always_comb begin
      state_nx = state;
      if (!alarm_en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    state_nx = ARMED;
            ARMED:   if (trig) state_nx = RINGING;
            RINGING: begin
               if (stop)                      state_nx = DONE;
               else if (snooze && can_snooze) state_nx = SNOOZE;
               else if (expire)               state_nx = DONE;
            end
            SNOOZE: begin
               if (stop)        state_nx = DONE;
               else if (expire) state_nx = RINGING;
            end
            // stay here until the matching minute ends so it cannot re-trigger
            DONE:    if (!match) state_nx = ARMED;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      used_nx = snooze_used;
      if ((state_nx == IDLE) || (state_nx == DONE)) begin
         used_nx = '0;
      end else if ((state == RINGING) && (state_nx == SNOOZE)) begin
         used_nx = snooze_used + SU_W'(1);
      end
   end

   always_comb begin
      ringer_nx = 1'b0;
`ifdef ALARM_BEEP_EN
      if (state_nx != RINGING)     ringer_nx = 1'b0;
      else if (state != RINGING)   ringer_nx = 1'b1;
      else if (tick_1s)            ringer_nx = ~ringer;
      else                         ringer_nx = ringer;
`else
      ringer_nx = (state_nx == RINGING);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         match_q     <= 1'b0;
         ringer      <= 1'b0;
         ringing     <= 1'b0;
         snoozing    <= 1'b0;
         snooze_used <= '0;
      end else begin
         state       <= state_nx;
         match_q     <= match;
         ringer      <= ringer_nx;
         ringing     <= (state_nx == RINGING);
         snoozing    <= (state_nx == SNOOZE);
         snooze_used <= used_nx;
      end
   end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: directed scenario tables plus
// randomized traffic against a countdown-style behavioural model.
module tb_alarm_ring_ctrl;

   localparam int RS  = 5;
   localparam int SS  = 3;
   localparam int MS  = 2;
   localparam int CW  = 9;
   localparam int SUW = $clog2(MS + 1);

   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_RING  = 2;
   localparam int M_SNZ   = 3;
   localparam int M_DONE  = 4;

   // row = {alarm_en, match, tick, snooze, stop, exp_ringing, exp_snoozing, exp_used[1:0]}
   localparam logic [8:0] T_BASIC [16] = '{
      9'b00_000_00_00, 9'b10_000_00_00, 9'b10_000_00_00, 9'b11_000_10_00,
      9'b11_100_10_00, 9'b11_000_10_00, 9'b11_100_10_00, 9'b11_100_10_00,
      9'b11_100_10_00, 9'b11_100_00_00, 9'b11_100_00_00, 9'b11_000_00_00,
      9'b10_000_00_00, 9'b11_000_10_00, 9'b11_001_00_00, 9'b10_000_00_00
   };
   localparam logic [8:0] T_SNOOZE [21] = '{
      9'b00_000_00_00, 9'b10_000_00_00, 9'b11_000_10_00, 9'b11_100_10_00,
      9'b11_010_01_01, 9'b11_100_01_01, 9'b11_100_01_01, 9'b11_010_01_01,
      9'b11_100_10_01, 9'b11_100_10_01, 9'b11_010_01_10, 9'b11_100_01_10,
      9'b11_100_01_10, 9'b11_100_10_10, 9'b11_010_10_10, 9'b11_100_10_10,
      9'b11_100_10_10, 9'b11_100_10_10, 9'b11_100_10_10, 9'b11_100_00_00,
      9'b10_000_00_00
   };
   localparam logic [8:0] T_STOP [14] = '{
      9'b00_000_00_00, 9'b10_000_00_00, 9'b11_000_10_00, 9'b11_010_01_01,
      9'b11_100_01_01, 9'b11_001_00_00, 9'b10_000_00_00, 9'b11_000_10_00,
      9'b11_011_00_00, 9'b11_100_00_00, 9'b10_000_00_00, 9'b11_000_10_00,
      9'b11_001_00_00, 9'b10_000_00_00
   };
   localparam logic [8:0] T_ENMID [9] = '{
      9'b00_000_00_00, 9'b01_000_00_00, 9'b11_000_00_00, 9'b11_100_00_00,
      9'b11_000_00_00, 9'b10_000_00_00, 9'b11_000_10_00, 9'b11_001_00_00,
      9'b10_000_00_00
   };
   localparam logic [8:0] T_DISABLE [9] = '{
      9'b00_000_00_00, 9'b10_000_00_00, 9'b11_000_10_00, 9'b11_100_10_00,
      9'b01_000_00_00, 9'b11_000_00_00, 9'b10_000_00_00, 9'b11_000_10_00,
      9'b11_010_01_01
   };

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b0;
   logic           tick_1s  = 1'b0;
   logic           match    = 1'b0;
   logic           alarm_en = 1'b0;
   logic           snooze   = 1'b0;
   logic           stop     = 1'b0;
   logic           ringer;
   logic           ringing;
   logic           snoozing;
   logic [SUW-1:0] snooze_used;

   int checks = 0;
   int fails  = 0;

   int m_mode = M_IDLE;
   int m_left = 0;
   int m_used = 0;
   bit m_prev = 1'b0;
   bit m_beep = 1'b0;

   alarm_ring_ctrl #(
      .RING_SECS   (RS),
      .SNOOZE_SECS (SS),
      .MAX_SNOOZE  (MS),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_1s     (tick_1s),
      .match       (match),
      .alarm_en    (alarm_en),
      .snooze      (snooze),
      .stop        (stop),
      .ringer      (ringer),
      .ringing     (ringing),
      .snoozing    (snoozing),
      .snooze_used (snooze_used)
   );

   always #5 clk = ~clk;

   // Reference: m_left counts down the seconds left in the current timed window
   function automatic void model_edge(input logic rn, input logic en, input logic m,
                                      input logic t, input logic sn, input logic st);
      int nm;
      if (!rn) begin
         m_mode = M_IDLE; m_left = 0; m_used = 0; m_prev = 1'b0; m_beep = 1'b0;
         return;
      end
      nm = m_mode;
      if (!en) begin
         nm = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         nm = M_ARMED;
      end else if (m_mode == M_ARMED) begin
         if (m && !m_prev) nm = M_RING;
      end else if (m_mode == M_RING) begin
         if (st) nm = M_DONE;
         else if (sn && m_used < MS) begin
            nm = M_SNZ;
            m_used = m_used + 1;
         end else if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) nm = M_DONE;
            else m_beep = !m_beep;
         end
      end else if (m_mode == M_SNZ) begin
         if (st) nm = M_DONE;
         else if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) nm = M_RING;
         end
      end else if (m_mode == M_DONE) begin
         if (!m) nm = M_ARMED;
      end
      if (nm == M_RING && m_mode != M_RING) begin
         m_left = RS;
         m_beep = 1'b1;
      end
      if (nm == M_SNZ && m_mode != M_SNZ) m_left = SS;
      if (nm == M_IDLE || nm == M_DONE) m_used = 0;
      m_mode = nm;
      m_prev = m;
   endfunction

   function automatic logic m_ringer();
`ifdef ALARM_BEEP_EN
      return (m_mode == M_RING) && m_beep;
`else
      return (m_mode == M_RING);
`endif
   endfunction

   function automatic logic [SUW+2:0] m_out();
      return {m_ringer(), logic'(m_mode == M_RING), logic'(m_mode == M_SNZ), SUW'(m_used)};
   endfunction

   task automatic step(input logic t, input logic sn, input logic st);
      tick_1s = t;
      snooze  = sn;
      stop    = st;
      @(posedge clk);
      model_edge(rst_n, alarm_en, match, t, sn, st);
      #1;
      tick_1s = 1'b0;
      snooze  = 1'b0;
      stop    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      alarm_en = 1'b1;
      match    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1);
         checks++;
         if ({ringer, ringing, snoozing, snooze_used} !== '0) begin
            fails++;
            $display("FAIL reset cycle %0d: outputs=%b required all zero", i,
                     {ringer, ringing, snoozing, snooze_used});
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_ring();
      for (int i = 0; i < 16; i++) begin
         alarm_en = T_BASIC[i][8];
         match    = T_BASIC[i][7];
         step(T_BASIC[i][6], T_BASIC[i][5], T_BASIC[i][4]);
         checks++;
         if ({ringing, snoozing, snooze_used} !== T_BASIC[i][3:0]) begin
            fails++;
            $display("FAIL basic_ring row %0d: ringing/snoozing/used=%b required %b", i,
                     {ringing, snoozing, snooze_used}, T_BASIC[i][3:0]);
         end
         checks++;
         if (ringer !== m_ringer()) begin
            fails++;
            $display("FAIL basic_ring ringer row %0d: got %b required %b", i, ringer, m_ringer());
         end
      end
   endtask

   task automatic test_snooze_cycle();
      for (int i = 0; i < 21; i++) begin
         alarm_en = T_SNOOZE[i][8];
         match    = T_SNOOZE[i][7];
         step(T_SNOOZE[i][6], T_SNOOZE[i][5], T_SNOOZE[i][4]);
         checks++;
         if ({ringing, snoozing, snooze_used} !== T_SNOOZE[i][3:0]) begin
            fails++;
            $display("FAIL snooze_cycle row %0d: ringing/snoozing/used=%b required %b", i,
                     {ringing, snoozing, snooze_used}, T_SNOOZE[i][3:0]);
         end
         checks++;
         if (ringer !== m_ringer()) begin
            fails++;
            $display("FAIL snooze_cycle ringer row %0d: got %b required %b", i, ringer, m_ringer());
         end
      end
   endtask

   task automatic test_stop();
      for (int i = 0; i < 14; i++) begin
         alarm_en = T_STOP[i][8];
         match    = T_STOP[i][7];
         step(T_STOP[i][6], T_STOP[i][5], T_STOP[i][4]);
         checks++;
         if ({ringing, snoozing, snooze_used} !== T_STOP[i][3:0]) begin
            fails++;
            $display("FAIL stop row %0d: ringing/snoozing/used=%b required %b", i,
                     {ringing, snoozing, snooze_used}, T_STOP[i][3:0]);
         end
         checks++;
         if (ringer !== m_ringer()) begin
            fails++;
            $display("FAIL stop ringer row %0d: got %b required %b", i, ringer, m_ringer());
         end
      end
   endtask

   task automatic test_enable_mid_minute();
      for (int i = 0; i < 9; i++) begin
         alarm_en = T_ENMID[i][8];
         match    = T_ENMID[i][7];
         step(T_ENMID[i][6], T_ENMID[i][5], T_ENMID[i][4]);
         checks++;
         if ({ringing, snoozing, snooze_used} !== T_ENMID[i][3:0]) begin
            fails++;
            $display("FAIL enable_mid_minute row %0d: ringing/snoozing/used=%b required %b", i,
                     {ringing, snoozing, snooze_used}, T_ENMID[i][3:0]);
         end
         checks++;
         if (ringer !== m_ringer()) begin
            fails++;
            $display("FAIL enable_mid_minute ringer row %0d: got %b required %b", i, ringer, m_ringer());
         end
      end
   endtask

   task automatic test_disable_reset();
      for (int i = 0; i < 9; i++) begin
         alarm_en = T_DISABLE[i][8];
         match    = T_DISABLE[i][7];
         step(T_DISABLE[i][6], T_DISABLE[i][5], T_DISABLE[i][4]);
         checks++;
         if ({ringing, snoozing, snooze_used} !== T_DISABLE[i][3:0]) begin
            fails++;
            $display("FAIL disable row %0d: ringing/snoozing/used=%b required %b", i,
                     {ringing, snoozing, snooze_used}, T_DISABLE[i][3:0]);
         end
         checks++;
         if (ringer !== m_ringer()) begin
            fails++;
            $display("FAIL disable ringer row %0d: got %b required %b", i, ringer, m_ringer());
         end
      end
      // currently snoozing with one snooze used; reset must clear everything at once
      rst_n = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if ({ringer, ringing, snoozing, snooze_used} !== '0) begin
         fails++;
         $display("FAIL reset_mid_snooze: outputs=%b required all zero",
                  {ringer, ringing, snoozing, snooze_used});
      end
      rst_n    = 1'b1;
      alarm_en = 1'b1;
      match    = 1'b0;
      step(1'b0, 1'b0, 1'b0);
   endtask

`ifdef ALARM_BEEP_EN
   task automatic test_beep();
      logic [5:0] seq;
      seq      = 6'b101010;
      alarm_en = 1'b0;
      match    = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      alarm_en = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      match = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(i != 0, 1'b0, 1'b0);
         checks++;
         if (ringer !== seq[5-i]) begin
            fails++;
            $display("FAIL beep step %0d: ringer=%b required %b", i, ringer, seq[5-i]);
         end
      end
      match = 1'b0;
      step(1'b0, 1'b0, 1'b0);
   endtask
`endif

   task automatic test_random();
      logic t, sn, st;
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 499) != 0);
         alarm_en = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 9) == 0) match = ~match;
         t  = ($urandom_range(0, 2) == 0);
         sn = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 24) == 0);
         step(t, sn, st);
         checks++;
         if ({ringer, ringing, snoozing, snooze_used} !== m_out()) begin
            fails++;
            $display("FAIL random cycle %0d: ringer/ringing/snoozing/used=%b required %b", i,
                     {ringer, ringing, snoozing, snooze_used}, m_out());
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_ring();
      test_snooze_cycle();
      test_stop();
      test_enable_mid_minute();
      test_disable_reset();
`ifdef ALARM_BEEP_EN
      test_beep();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

- Sequences the alarm ringer from the alarm/time comparator's match output.
- Arms the alarm and detects the start of the matching minute.
- Drives the ringer for a bounded time, handles snooze and stop requests, and keeps the alarm from re-triggering within the same minute.
- Sits between the comparator and the ringer/beeper driver; counts time from the clock divider's 1 Hz strobe.

## Interface
Parameters:
- RING_SECS, 60, auto-stop length of one ringing episode, in seconds (≥1).
- SNOOZE_SECS, 300, snooze length in seconds (≥1).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0 disables snooze).
- CNT_W, 9, second-counter width; RING_SECS and SNOOZE_SECS must each be < 2^CNT_W.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- tick_1s  in  1  one-cycle strobe, once per second.
- match  in  1  comparator output; high for the whole matching minute.
- alarm_en  in  1  level, alarm armed when high.
- snooze  in  1  one-cycle request pulse.
- stop  in  1  one-cycle request pulse.
- ringer  out  1  ringer drive.
- ringing  out  1  high in the RINGING state.
- snoozing  out  1  high in the SNOOZE state.
- snooze_used  out  $clog2(MAX_SNOOZE+1)  snoozes consumed in the current event.

## Operation
- States: IDLE, ARMED, RINGING, SNOOZE, DONE.
- match_q samples match every cycle, in every state. The trigger is match & ~match_q, i.e. a rising edge.
- IDLE → ARMED when alarm_en = 1.
- ARMED → RINGING on a trigger. Enabling the alarm during a matching minute does not ring, because no edge occurs.
- RINGING:
  - stop → DONE.
  - snooze with snooze_used < MAX_SNOOZE → SNOOZE, and snooze_used increments.
  - snooze at the limit is ignored.
  - RING_SECS ticks elapsed → DONE (auto-off).
- SNOOZE:
  - stop → DONE.
  - SNOOZE_SECS ticks elapsed → RINGING, with a fresh RING_SECS window.
  - snooze is ignored.
- DONE → ARMED when match = 0. This blocks re-trigger within the same minute.
- alarm_en = 0 forces IDLE from any state on the next edge.
- Priority in the same cycle: alarm_en low > stop > snooze > counter expiry.
- snooze_used clears on entry to DONE or IDLE.
- Second counter:
  - Clears on every state entry.
  - Increments on tick_1s while in RINGING or SNOOZE.
  - Expiry fires when tick_1s arrives with the count equal to LIMIT−1, giving exactly LIMIT ticks.
  - A tick in the entry cycle is not counted.
- ringer is 1 only in RINGING (see Configuration). ringing and snoozing decode the state.

## Timing
- All outputs are registered.
- Reset values: state = IDLE, ringer = 0, ringing = 0, snoozing = 0, snooze_used = 0, counter = 0, match_q = 0.
- Reset is honoured mid-ring or mid-snooze: outputs are 0 in the cycle after rst_n is sampled low.
- Trigger sampled at edge t → ringing = 1 and ringer = 1 after edge t+1 (one-cycle latency). The same latency applies to stop, snooze and expiry.
- IDLE → ARMED takes one cycle, so match_q is valid before edge detection begins.
- stop and snooze pulses arriving in states where they are not listed are dropped. They are not queued.

## Configuration
- ALARM_BEEP_EN defined:
  - ringer toggles on each tick_1s while in RINGING.
  - ringer = 1 on entry to RINGING.
  - ringer is forced 0 outside RINGING.
  - This gives a 0.5 Hz on/off beep.
- ALARM_BEEP_EN undefined: ringer equals ringing (steady tone).
- State timing is identical in both builds.

## Structure
- Package alarm_pkg holds:
  - the state enum alarm_state_t;
  - the default constants DEF_RING_SECS, DEF_SNOOZE_SECS, DEF_MAX_SNOOZE.
- One sub-module, sec_counter:
  - tick-enabled counter with synchronous clear and a LIMIT input;
  - produces a one-cycle expire output;
  - one instance, whose LIMIT is muxed between RING_SECS and SNOOZE_SECS by state.

## Test plan
Parameters for all scenarios: RING_SECS = 5, SNOOZE_SECS = 3, MAX_SNOOZE = 2.

- **Basic ring:** alarm_en = 1, raise match → ringer = 1 one cycle later. After 5 ticks ringer = 0 and state = DONE. Drop match → ARMED. No re-ring while match is held high.
- **Snooze cycle:** snooze during ring → snoozing = 1, snooze_used = 1. After 3 ticks ringing = 1 again. Second snooze → snooze_used = 2. Third snooze ignored, and ringing continues to auto-off.
- **Stop:** stop during SNOOZE → DONE with snooze_used = 0. Same-cycle stop + snooze in RINGING → DONE (stop wins).
- **Enable mid-minute:** match already high, then alarm_en 0 → 1 → no ring. Next match rising edge rings.
- **Disable/reset:** alarm_en = 0 while ringing → IDLE with ringer = 0 next cycle. rst_n low mid-snooze → all outputs 0 next cycle.
- **Beep build (ALARM_BEEP_EN):** ringer sequence across ticks is 1, 0, 1, 0, 1, then 0 at auto-off.
